// File: rtl/bram_master.sv
// bram_master: initiator for a byte-lane synchronous block RAM.
// Turns valid/ready load/store/burst requests into lane strobes and returns extended read data.
module bram_master #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned BURST_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  input  logic [BURST_WIDTH-1:0] req_len,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   rsp_last,
  output logic [ADDR_WIDTH-3:0]  mem_addr,
  output logic [3:0]             mem_cs_n,
  output logic [3:0]             mem_we_n,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [1:0]             off_q, off_d;
  logic [1:0]             size_q, size_d;
  logic                   uns_q, uns_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   rsp_last_q, rsp_last_d;

  logic        rsp_free;
  logic        accept;
  logic        issue_busy;
  logic        req_err;
  logic        req_burst;
  logic [3:0]  req_lanes;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_ext;

  // Lane decode, alignment check and store-data replication for the incoming request.
  always_comb begin
    req_err   = 1'b0;
    req_lanes = 4'h0;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        req_lanes = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_lanes = req_addr[1] ? 4'b1100 : 4'b0011;
        req_err   = req_addr[0];
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        req_lanes = 4'hF;
        req_err   = (req_addr[1:0] != 2'b00);
      end
      default: req_err = 1'b1;
    endcase
  end

  assign req_burst  = !req_we && (req_size == SZ_WORD) && (req_len != '0);
  assign rsp_free   = !rsp_valid_q || rsp_ready;
  assign req_ready  = !reset && (state_q != BUSY) && rsp_free;
  assign accept     = req_valid && req_ready;
  assign issue_busy = !reset && (state_q == BUSY) && rsp_free;

  // Next-state, response bookkeeping and the combinational RAM strobes.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_pend_d    = rd_pend_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_last_d   = rsp_last_q;
    mem_addr     = req_addr[ADDR_WIDTH-1:2];
    mem_cs_n     = 4'hF;
    mem_we_n     = 4'hF;
    mem_wdata    = wdata_rep;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_last_d  = 1'b0;
      rd_pend_d   = 1'b0;
    end

    if (accept) begin
      if (req_err) begin
        rsp_valid_d  = 1'b1;
        rsp_err_d    = 1'b1;
        rsp_last_d   = 1'b1;
        rd_pend_d    = 1'b0;
        beats_left_d = '0;
        state_d      = ERR;
      end else begin
        mem_cs_n     = ~req_lanes;
        mem_we_n     = req_we ? ~req_lanes : 4'hF;
        rsp_valid_d  = 1'b1;
        rsp_err_d    = 1'b0;
        rsp_last_d   = !req_burst;
        rd_pend_d    = !req_we;
        off_d        = req_addr[1:0];
        size_d       = req_size;
        uns_d        = req_unsigned;
        addr_d       = req_addr + ADDR_WIDTH'(4);
        beats_left_d = req_burst ? req_len : '0;
        state_d      = req_burst ? BUSY : IDLE;
      end
    end else if (issue_busy) begin
      // Next burst beat: the RAM output register is free once the prior beat is consumed.
      mem_addr     = addr_q[ADDR_WIDTH-1:2];
      mem_cs_n     = 4'h0;
      rsp_valid_d  = 1'b1;
      rsp_err_d    = 1'b0;
      rsp_last_d   = (beats_left_q == BURST_WIDTH'(1));
      rd_pend_d    = 1'b1;
      addr_d       = addr_q + ADDR_WIDTH'(4);
      beats_left_d = beats_left_q - BURST_WIDTH'(1);
      if (beats_left_q == BURST_WIDTH'(1)) begin
        state_d = IDLE;
      end
    end else if ((state_q == ERR) && rsp_valid_q && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      rd_pend_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_pend_q    <= rd_pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  // Read data comes straight from the RAM output register, which holds until the next read.
  always_comb begin
    rdata_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: rdata_ext = uns_q ? {24'h0, rdata_shift[7:0]}
                                 : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      SZ_HALF: rdata_ext = uns_q ? {16'h0, rdata_shift[15:0]}
                                 : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: rdata_ext = mem_rdata;
    endcase
    rsp_data = (rd_pend_q && !reset) ? rdata_ext : 32'h0;
  end

  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_err   = rsp_err_q && !reset;
  assign rsp_last  = rsp_last_q && !reset;

endmodule
